fft_r2_seq: RTL and testbench
=============================

FFT_R2_SEQ -- requirements
Module: fft_r2_seq

Interface
REQ-001 SHALL have parameter LOG2N, default 6, meaning log2 of transform size N (N = 2^LOG2N, legal 2..10).
REQ-002 SHALL have parameter BF_LAT, default 2, meaning butterfly latency in cycles from bf_en to y0/y1 valid.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin one full in-place FFT pass.
REQ-006 SHALL have port busy  output  1  high from first issue cycle through last write cycle.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the final write.
REQ-008 SHALL have port rd_en  output  1  operand-memory read strobe.
REQ-009 SHALL have ports rd_addr_a, rd_addr_b  output  LOG2N  butterfly operand read addresses.
REQ-010 SHALL have port tw_addr  output  LOG2N-1  twiddle ROM index, valid with rd_en.
REQ-011 SHALL have port bf_en  output  1  butterfly enable, equal to rd_en delayed 1 cycle (1-cycle memory read).
REQ-012 SHALL have ports wr_en  output  1, and wr_addr_a, wr_addr_b  output  LOG2N, the write-back strobe and addresses for y0/y1.
REQ-013 SHALL have port stage  output  clog2(LOG2N)  current stage index.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> (ISSUE for next stage | FIN) -> IDLE.
REQ-015 In IDLE, start=1 SHALL move to ISSUE with stage=0 and butterfly counter bf=0; the first rd_en appears the next cycle.
REQ-016 In ISSUE, rd_en SHALL be high every cycle, bf incrementing 0..N/2-1, then DRAIN.
REQ-017 Address rule for stage s, span=2^s, k=bf mod span, g=bf>>s: rd_addr_a=(g<<(s+1))|k; rd_addr_b=rd_addr_a+span; tw_addr=k<<(LOG2N-1-s).
REQ-018 wr_en/wr_addr_a/wr_addr_b SHALL equal rd_en/rd_addr_a/rd_addr_b delayed exactly BF_LAT+1 cycles through a shift pipeline.
REQ-019 DRAIN SHALL last exactly BF_LAT+1 cycles, so no read of stage s+1 precedes the final write of stage s (RAW hazard free).
REQ-020 After DRAIN of stage LOG2N-1, FSM SHALL enter FIN, pulse done for one cycle, and return to IDLE.
REQ-021 Stage period SHALL be N/2+BF_LAT+1 cycles; total from start cycle to done cycle = LOG2N*(N/2+BF_LAT+1)+1.
REQ-022 start while not IDLE SHALL be ignored; start coinciding with done SHALL be ignored.
REQ-023 bf and stage counters SHALL wrap to 0 at their terminal values, never exceeding N/2-1 or LOG2N-1.

Reset
REQ-024 rst SHALL asynchronously force IDLE, zero all counters and pipeline stages, and drive every output to 0, including mid-pass; no pending write SHALL emerge after reset release.

Configuration
REQ-025 With FFT_R2_SEQ_HOLD_EN defined, an input port hold (1 bit) SHALL exist; hold=1 freezes FSM, counters and the entire rd/bf/wr pipeline, with rd_en, bf_en and wr_en forced 0 while held, and operation resumes unchanged on release.
REQ-026 Without FFT_R2_SEQ_HOLD_EN, port hold SHALL be absent and the sequencer never stalls.

Structure
REQ-027 FSM state encoding and default LOG2N/BF_LAT constants SHALL reside in the shared FFT package.
REQ-028 Address generation (REQ-017) SHALL be one combinational sub-module fft_r2_addr_gen; pipeline and FSM stay in fft_r2_seq.

Verification (LOG2N=3, BF_LAT=2 unless stated)
REQ-029 start at cycle 0 -> stage0 rd pairs (0,1),(2,3),(4,5),(6,7) at cycles 1-4, tw_addr all 0.
REQ-030 Stage1 -> pairs (0,2),(1,3),(4,6),(5,7) at cycles 8-11, tw_addr 0,2,0,2; stage2 -> (0,4),(1,5),(2,6),(3,7) at cycles 15-18, tw_addr 0,1,2,3.
REQ-031 wr_en high cycles 4-7, 11-14, 18-21 with addresses matching reads 3 cycles earlier; done pulses at cycle 22 only; busy high cycles 1-21.
REQ-032 rst asserted at cycle 10 -> all outputs 0 immediately, no wr_en after release, new start runs a clean full pass.
REQ-033 start pulsed at cycles 5 and 22 -> ignored, no second pass.
REQ-034 With FFT_R2_SEQ_HOLD_EN, hold high cycles 2-4 -> reads resume at pair (2,3) on cycle 5 and done shifts to cycle 25.

Source files
------------

// File: rtl/fft_r2_seq_pkg.sv
// Shared constants and FSM encoding for the radix-2 in-place FFT sequencer.
// Optional stall input enabled by FFT_R2_SEQ_HOLD_EN.
package fft_r2_seq_pkg;

   localparam int LOG2N_DEF  = 6;
   localparam int BF_LAT_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FIN
   } state_e;

endpackage

// File: rtl/fft_r2_seq_if.sv
// Control/address bundle between the FFT sequencer and its controller,
// operand memory, twiddle ROM and butterfly.
interface fft_r2_seq_if
   import fft_r2_seq_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF
) ();

   localparam int SW = $clog2(LOG2N);

   logic             start;
   logic             busy;
   logic             done;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             bf_en;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;
   logic [SW-1:0]    stage;

   modport master (
      input  start,
      output busy, done,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output bf_en,
      output wr_en, wr_addr_a, wr_addr_b,
      output stage
   );

   modport slave (
      output start,
      input  busy, done,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  bf_en,
      input  wr_en, wr_addr_a, wr_addr_b,
      input  stage
   );

endinterface

// File: rtl/fft_r2_addr_gen.sv
// Combinational butterfly operand and twiddle address generator
// for one (stage, butterfly) pair of an in-place radix-2 FFT.
module fft_r2_addr_gen
   import fft_r2_seq_pkg::*;
#(
   parameter  int LOG2N = LOG2N_DEF,
   localparam int SW    = $clog2(LOG2N)
) (
   input  logic [SW-1:0]    i_stage,
   input  logic [LOG2N-2:0] i_bf,
   output logic [LOG2N-1:0] o_addr_a,
   output logic [LOG2N-1:0] o_addr_b,
   output logic [LOG2N-2:0] o_tw
);

   logic [LOG2N-2:0] w_mask;
   logic [LOG2N-2:0] w_k;
   logic [LOG2N-2:0] w_g;
   logic [LOG2N-1:0] w_span;
   logic [LOG2N-1:0] w_a;
   logic [SW-1:0]    w_tw_sh;

   assign w_mask  = ~({(LOG2N-1){1'b1}} << i_stage);
   assign w_k     = i_bf & w_mask;
   assign w_g     = i_bf >> i_stage;
   assign w_span  = LOG2N'(1) << i_stage;
   // Bit s of addr_a is always clear, so OR-ing in span is the +span.
   assign w_a     = ({w_g, 1'b0} << i_stage) | {1'b0, w_k};
   assign w_tw_sh = SW'(LOG2N-1) - i_stage;

   assign o_addr_a = w_a;
   assign o_addr_b = w_a | w_span;
   assign o_tw     = w_k << w_tw_sh;

endmodule

// File: rtl/fft_r2_seq.sv
// Radix-2 in-place FFT pass sequencer: issues reads, pipes write-backs.
// Define FFT_R2_SEQ_HOLD_EN to add a hold input that freezes everything.
module fft_r2_seq
   import fft_r2_seq_pkg::*;
#(
   parameter int LOG2N  = LOG2N_DEF,
   parameter int BF_LAT = BF_LAT_DEF
) (
   input  logic         clk,
   input  logic         rst,
`ifdef FFT_R2_SEQ_HOLD_EN
   input  logic         hold,
`endif
   fft_r2_seq_if.master seq
);

   localparam int SW = $clog2(LOG2N);
   localparam int HW = LOG2N - 1;
   localparam int DW = $clog2(BF_LAT + 2);

   localparam logic [HW-1:0] BF_LAST  = '1;
   localparam logic [SW-1:0] STG_LAST = SW'(LOG2N - 1);
   localparam logic [DW-1:0] DRN_LAST = DW'(BF_LAT);

   state_e        r_state, w_state_nxt;
   logic [HW-1:0] r_bf, w_bf_nxt;
   logic [SW-1:0] r_stage, w_stage_nxt;
   logic [DW-1:0] r_drn, w_drn_nxt;

   logic w_stall;
   logic w_run;

`ifdef FFT_R2_SEQ_HOLD_EN
   assign w_stall = hold;
`else
   assign w_stall = 1'b0;
`endif
   assign w_run = ~w_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_bf    <= '0;
         r_stage <= '0;
         r_drn   <= '0;
      end else if (w_run) begin
         r_state <= w_state_nxt;
         r_bf    <= w_bf_nxt;
         r_stage <= w_stage_nxt;
         r_drn   <= w_drn_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bf_nxt    = r_bf;
      w_stage_nxt = r_stage;
      w_drn_nxt   = r_drn;
      unique case (r_state)
         S_IDLE: begin
            if (seq.start) begin
               w_state_nxt = S_ISSUE;
               w_bf_nxt    = '0;
               w_stage_nxt = '0;
               w_drn_nxt   = '0;
            end
         end
         S_ISSUE: begin
            if (r_bf == BF_LAST) begin
               w_bf_nxt    = '0;
               w_drn_nxt   = '0;
               w_state_nxt = S_DRAIN;
            end else begin
               w_bf_nxt = r_bf + 1'b1;
            end
         end
         S_DRAIN: begin
            // Wait out the write pipe so the next stage never reads stale data.
            if (r_drn == DRN_LAST) begin
               w_drn_nxt = '0;
               if (r_stage == STG_LAST) begin
                  w_stage_nxt = '0;
                  w_state_nxt = S_FIN;
               end else begin
                  w_stage_nxt = r_stage + 1'b1;
                  w_state_nxt = S_ISSUE;
               end
            end else begin
               w_drn_nxt = r_drn + 1'b1;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   logic [LOG2N-1:0] w_ra, w_rb;
   logic [LOG2N-2:0] w_tw;
   logic             w_rd;
   logic [LOG2N-1:0] w_ra_g, w_rb_g;

   fft_r2_addr_gen #(
      .LOG2N (LOG2N)
   ) u_addr_gen (
      .i_stage  (r_stage),
      .i_bf     (r_bf),
      .o_addr_a (w_ra),
      .o_addr_b (w_rb),
      .o_tw     (w_tw)
   );

   assign w_rd   = (r_state == S_ISSUE) & w_run;
   assign w_ra_g = w_rd ? w_ra : '0;
   assign w_rb_g = w_rd ? w_rb : '0;

   logic [BF_LAT:0]  r_pv;
   logic [LOG2N-1:0] r_pa [BF_LAT+1];
   logic [LOG2N-1:0] r_pb [BF_LAT+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pv <= '0;
         for (int i = 0; i <= BF_LAT; i++) begin
            r_pa[i] <= '0;
            r_pb[i] <= '0;
         end
      end else if (w_run) begin
         r_pv[0] <= w_rd;
         r_pa[0] <= w_ra_g;
         r_pb[0] <= w_rb_g;
         for (int i = 1; i <= BF_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
            r_pb[i] <= r_pb[i-1];
         end
      end
   end

   assign seq.busy      = (r_state == S_ISSUE) | (r_state == S_DRAIN);
   assign seq.done      = (r_state == S_FIN) & w_run;
   assign seq.rd_en     = w_rd;
   assign seq.rd_addr_a = w_ra_g;
   assign seq.rd_addr_b = w_rb_g;
   assign seq.tw_addr   = w_rd ? w_tw : '0;
   assign seq.bf_en     = r_pv[0] & w_run;
   assign seq.wr_en     = r_pv[BF_LAT] & w_run;
   assign seq.wr_addr_a = r_pa[BF_LAT];
   assign seq.wr_addr_b = r_pb[BF_LAT];
   assign seq.stage     = r_stage;

endmodule

// File: tb/tb_fft_r2_seq.sv
// Bench for fft_r2_seq (LOG2N=3, BF_LAT=2): per-cycle reference model,
// fixed vector tables, reset/start-ignore/hold sequences, random passes.
module tb_fft_r2_seq;

   localparam int L2     = 3;
   localparam int LAT    = 2;
   localparam int HALF   = 4;
   localparam int P      = HALF + LAT + 1;
   localparam int DONE_T = L2 * P + 1;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic hold = 1'b0;

   always #5 clk = ~clk;

   fft_r2_seq_if #(.LOG2N(L2)) u_if ();

   fft_r2_seq #(
      .LOG2N  (L2),
      .BF_LAT (LAT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
`ifdef FFT_R2_SEQ_HOLD_EN
      .hold (hold),
`endif
      .seq  (u_if)
   );

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rd;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [1:0] tw;
      logic       bf;
      logic       wr;
      logic [2:0] wa;
      logic [2:0] wb;
      logic [1:0] stg;
   } obs_t;

   typedef struct {
      int cyc;
      int a;
      int b;
      int tw;
   } rd_vec_t;

   typedef struct {
      int cyc;
      bit busy;
      bit wr;
      bit done;
      int wa;
      int wb;
   } fl_vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t obs [128];

   function automatic obs_t sample();
      obs_t o;
      o.busy = u_if.busy;
      o.done = u_if.done;
      o.rd   = u_if.rd_en;
      o.ra   = u_if.rd_addr_a;
      o.rb   = u_if.rd_addr_b;
      o.tw   = u_if.tw_addr;
      o.bf   = u_if.bf_en;
      o.wr   = u_if.wr_en;
      o.wa   = u_if.wr_addr_a;
      o.wb   = u_if.wr_addr_b;
      o.stg  = u_if.stage;
      return o;
   endfunction

   task automatic chk(input string nm, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Butterfly j of stage s pairs elements a and a+span inside group g.
   function automatic void pair(input int s, input int j,
                                output int a, output int b,
                                output int tw);
      int span;
      int k;
      int g;
      span = 1 << s;
      k    = j % span;
      g    = j / span;
      a    = g * 2 * span + k;
      b    = a + span;
      tw   = k * (HALF / span);
   endfunction

   function automatic bit is_rd(input int p);
      return p >= 1 && p <= L2 * P && ((p - 1) % P) < HALF;
   endfunction

   // Expected outputs p active cycles after the accepted start.
   function automatic obs_t model(input int p);
      obs_t e;
      int   a, b, tw, q;
      e = '0;
      if (p >= 1 && p <= L2 * P) begin
         e.busy = 1'b1;
         e.stg  = 2'((p - 1) / P);
      end
      if (is_rd(p)) begin
         pair((p - 1) / P, (p - 1) % P, a, b, tw);
         e.rd = 1'b1;
         e.ra = 3'(a);
         e.rb = 3'(b);
         e.tw = 2'(tw);
      end
      if (is_rd(p - 1)) e.bf = 1'b1;
      q = p - (LAT + 1);
      if (is_rd(q)) begin
         pair((q - 1) / P, (q - 1) % P, a, b, tw);
         e.wr = 1'b1;
         e.wa = 3'(a);
         e.wb = 3'(b);
      end
      if (p == DONE_T) e.done = 1'b1;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 no hold, 1 hold on cycles 2-4, 2 random hold.
   // noise: 0 none, 1 start at cycles 5 and 22, 2 random start while busy.
   task automatic run_pass(input int mode, input int noise);
      int   idx;
      bit   h;
      obs_t e;
      u_if.start = 1'b1;
      hold = 1'b0;
      #1;
      obs[0] = sample();
      chk("start_cycle", obs[0], '0);
      tick();
      idx = 1;
      for (int c = 1; c < 128 && idx <= DONE_T + 2; c++) begin
         h = 1'b0;
         if (mode == 1) h = (c >= 2 && c <= 4);
         if (mode == 2) h = ($urandom_range(0, 3) == 0);
`ifndef FFT_R2_SEQ_HOLD_EN
         h = 1'b0;
`endif
         hold = h;
         u_if.start = 1'b0;
         if (noise == 1) u_if.start = (c == 5 || c == 22);
         if (noise == 2 && idx <= DONE_T)
            u_if.start = ($urandom_range(0, 2) == 0);
         #1;
         e = model(idx);
         if (h) begin
            e.rd = 0; e.ra = 0; e.rb = 0; e.tw = 0;
            e.bf = 0; e.wr = 0; e.done = 0;
         end
         obs[c] = sample();
         chk($sformatf("cyc%0d_idx%0d", c, idx), obs[c], e);
         if (!h) idx++;
         tick();
      end
      if (idx <= DONE_T + 2) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pass_timeout: reached %0d want %0d", idx, DONE_T + 3);
      end
      u_if.start = 1'b0;
      hold = 1'b0;
   endtask

   rd_vec_t rd_tab [12];
   fl_vec_t fl_tab [13];

   initial begin
      u_if.start = 1'b0;

      rd_tab[0]  = '{1, 0, 1, 0};
      rd_tab[1]  = '{2, 2, 3, 0};
      rd_tab[2]  = '{3, 4, 5, 0};
      rd_tab[3]  = '{4, 6, 7, 0};
      rd_tab[4]  = '{8, 0, 2, 0};
      rd_tab[5]  = '{9, 1, 3, 2};
      rd_tab[6]  = '{10, 4, 6, 0};
      rd_tab[7]  = '{11, 5, 7, 2};
      rd_tab[8]  = '{15, 0, 4, 0};
      rd_tab[9]  = '{16, 1, 5, 1};
      rd_tab[10] = '{17, 2, 6, 2};
      rd_tab[11] = '{18, 3, 7, 3};

      fl_tab[0]  = '{0, 0, 0, 0, 0, 0};
      fl_tab[1]  = '{1, 1, 0, 0, 0, 0};
      fl_tab[2]  = '{3, 1, 0, 0, 0, 0};
      fl_tab[3]  = '{4, 1, 1, 0, 0, 1};
      fl_tab[4]  = '{7, 1, 1, 0, 6, 7};
      fl_tab[5]  = '{8, 1, 0, 0, 0, 0};
      fl_tab[6]  = '{11, 1, 1, 0, 0, 2};
      fl_tab[7]  = '{14, 1, 1, 0, 5, 7};
      fl_tab[8]  = '{15, 1, 0, 0, 0, 0};
      fl_tab[9]  = '{18, 1, 1, 0, 0, 4};
      fl_tab[10] = '{21, 1, 1, 0, 3, 7};
      fl_tab[11] = '{22, 0, 0, 1, 0, 0};
      fl_tab[12] = '{23, 0, 0, 0, 0, 0};

      tick();
      tick();
      chk("reset_state", sample(), '0);
      rst = 1'b0;
      tick();
      chk("idle_after_reset", sample(), '0);

      run_pass(0, 0);
      for (int i = 0; i < 12; i++) begin
         chk_int($sformatf("tab_rd_c%0d", rd_tab[i].cyc),
                 {obs[rd_tab[i].cyc].rd, obs[rd_tab[i].cyc].ra,
                  obs[rd_tab[i].cyc].rb, obs[rd_tab[i].cyc].tw},
                 {1'b1, 3'(rd_tab[i].a), 3'(rd_tab[i].b),
                  2'(rd_tab[i].tw)});
      end
      for (int i = 0; i < 13; i++) begin
         chk_int($sformatf("tab_fl_c%0d", fl_tab[i].cyc),
                 {obs[fl_tab[i].cyc].busy, obs[fl_tab[i].cyc].wr,
                  obs[fl_tab[i].cyc].done, obs[fl_tab[i].cyc].wa,
                  obs[fl_tab[i].cyc].wb},
                 {fl_tab[i].busy, fl_tab[i].wr, fl_tab[i].done,
                  3'(fl_tab[i].wa), 3'(fl_tab[i].wb)});
      end

      tick();
      run_pass(0, 1);

      tick();
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      repeat (9) tick();
      chk_int("mid_pass_busy", int'(u_if.busy), 1);
      #2 rst = 1'b1;
      #1 chk("rst_async", sample(), '0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1 chk($sformatf("post_rst_%0d", i), sample(), '0);
         tick();
      end
      run_pass(0, 0);

`ifdef FFT_R2_SEQ_HOLD_EN
      tick();
      run_pass(1, 0);
      chk_int("hold_resume_c5", {obs[5].rd, obs[5].ra, obs[5].rb},
              {1'b1, 3'd2, 3'd3});
      chk_int("hold_done_c24", int'(obs[24].done), 0);
      chk_int("hold_done_c25", int'(obs[25].done), 1);
`endif

      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(1, 4)) tick();
         run_pass(2, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: still running want finished");
      $fatal(1, "timeout");
   end

endmodule
